dll_dllp_rx_decoder: RTL and testbench
======================================

# dll_dllp_rx_decoder

Multi-slot, pipelined receive decoder for Data Link Layer Packets (DLLPs). It sits between the PIPE receive interface and the DLCMSM / transaction-layer credit logic. Each beat can carry up to SLOT_CNT framed DLLPs, and the block checks all of them in parallel. It CRC-checks each DLLP, then decodes InitFC1/InitFC2/UpdateFC/Ack/Nak into registered credit, flag and sequence outputs, and counts errors.

## Interface
- PIPE_DATA_WIDTH, 256: input beat width; must be ≥ 64·SLOT_CNT.
- SLOT_CNT, 2: DLLP slots decoded per beat, range 1..PIPE_DATA_WIDTH/64.
- CREDIT_DEPTH, 12: credit output width; must be ≥ 12.
- ERR_CNT_W, 16: width of the error counters.

Ports:
- sclk  in  1  clock.
- srst_n  in  1  synchronous, active-low reset.
- clear_i  in  1  synchronous link-down clear; same effect as reset.
- pipe2dll_valid_i  in  1  beat valid.
- pipe2dll_data_i  in  PIPE_DATA_WIDTH  beat; slot k = bits [64k+63:64k].
- init1_received_o  out  1  InitFC1 seen for P, NP and CPL.
- init2_received_o  out  1  InitFC2 seen for P, NP and CPL.
- ep_cl_{p,np,cpl}_h_o, ep_cl_{p,np,cpl}_d_o  out  CREDIT_DEPTH each  InitFC1 header/data credit limits.
- ep_cc_{p,np,cpl}_h_o, ep_cc_{p,np,cpl}_d_o  out  CREDIT_DEPTH each  latest UpdateFC header/data values.
- ack_valid_o  out  1  one-cycle pulse; an Ack was decoded.
- ack_seq_o  out  12  Ack sequence number; held between pulses.
- nak_valid_o  out  1  one-cycle pulse; a Nak was decoded.
- nak_seq_o  out  12  Nak sequence number; held between pulses.
- crc_err_cnt_o  out  ERR_CNT_W  saturating count of CRC failures.
- unk_type_cnt_o  out  ERR_CNT_W  saturating count of unknown DLLP types.

## Operation
- Slot format: [15:0] framing token; the slot is active only if the token is 16'hACF0. Body is bits [47:16], type is [23:16], CRC is [63:48].
- Field extraction:
  - Header credit = {slot[29:24], slot[39:38]}, zero-extended to CREDIT_DEPTH.
  - Data credit = {slot[35:32], slot[47:40]}, zero-extended.
  - Sequence number = {slot[35:32], slot[47:40]}.
- CRC: 16-bit LFSR, polynomial 16'h100B, seed 16'hFFFF, shifts body bit 31 first through bit 0. The slot passes if slot[63:48] equals the bitwise inverse of the final LFSR value.
- A slot that fails CRC increments crc_err_cnt and has no other effect.
- Type decode for CRC-passing slots:
  - 8'h40, 8'h50, 8'h60: InitFC1 for P, NP, CPL. Loads ep_cl h/d and sets that type's init1 flag.
  - 8'hC0, 8'hD0, 8'hE0: InitFC2 for P, NP, CPL. Sets that type's init2 flag.
  - 8'h80, 8'h90, 8'hA0: UpdateFC for P, NP, CPL. Loads ep_cc h/d.
  - 8'h00: Ack. 8'h10: Nak.
  - Any other type increments unk_type_cnt.
- Once init2_received_o is 1, later InitFC1/InitFC2 DLLPs are dropped silently: no counter change, no output change.
- init1_received_o is the AND of the three init1 flags, not of the credit values. A credit value of 0 (infinite) is legal and still sets the flag.
- Same-beat conflicts:
  - If several slots target the same register, the highest slot index wins.
  - An Ack and a Nak in one beat both pulse, each carrying its own highest-index sequence number.
- Counters:
  - Each counter adds the number of qualifying slots in the beat (0..SLOT_CNT).
  - Each counter saturates at all-ones and never wraps.
- Reset or clear_i: every register and every output goes to 0, including flags, credits, sequence numbers, pulses and counters.
- clear_i and reset discard everything in flight: beats in pipeline stages 1–2 produce no effect.

## Timing
- Stage 1 (edge N+1): registers the beat, the per-slot active bits and valid.
- Stage 2 (edge N+2): runs CRC and decode, then updates all output registers.
- For a beat accepted at edge N, outputs are visible in the cycle after edge N+2.
- Fixed latency of 2. No backpressure: one beat can be accepted every cycle.
- ack_valid_o and nak_valid_o are high for exactly one cycle per decoding beat. Back-to-back beats give back-to-back pulses.
- No combinational path from any input to any output.
- clear_i asserted at edge M: all outputs are 0 after M, and any beat presented at M is dropped.

## Test plan
- Init sequence: InitFC1 P (hdr 8'h20, data 12'h100) in beat 1, then NP and CPL in two beats; then InitFC2 ×3.
  - Required: ep_cl_p_h_o = 12'h020 and ep_cl_p_d_o = 12'h100.
  - init1_received_o rises 2 cycles after the third InitFC1; init2_received_o rises 2 cycles after the third InitFC2.
- Dual-slot beat: slot0 UpdateFC P hdr 8'h05, slot1 UpdateFC P hdr 8'h09.
  - Required: ep_cc_p_h_o = 12'h009, and no change to the error counters.
- Corrupted CRC: flip body bit 0 of a valid Ack (seq 12'h3A5).
  - Required: no ack pulse, ack_seq_o unchanged, crc_err_cnt_o increments by 1.
  - Then inject a 2-slot beat with both slots bad: count increments by 2.
- Ack and Nak in one beat: slot0 Ack seq 12'h010, slot1 Nak seq 12'h00F.
  - Required: both pulses in the same cycle, with ack_seq_o = 12'h010 and nak_seq_o = 12'h00F.
- Saturation and late-init drop:
  - Preload unk_type_cnt_o to 16'hFFFE via beats of type 8'h30, then send 2 more: count holds at 16'hFFFF.
  - With init2_received_o = 1, send InitFC1 P hdr 8'h7F: ep_cl_p_h_o is unchanged.
- clear_i mid-stream: assert clear_i while an UpdateFC is in stage 1.
  - Required: all outputs are 0 the next cycle, and the in-flight UpdateFC never appears.

Source files
------------

// File: rtl/dll_dllp_rx_decoder.sv
// rtl/dll_dllp_rx_decoder.sv - Two-stage multi-slot DLLP receive decoder
// Stage 1 captures the beat and per-slot framing; stage 2 CRC-checks, decodes and updates outputs.
module dll_dllp_rx_decoder #(
  parameter int PIPE_DATA_WIDTH = 256,
  parameter int SLOT_CNT        = 2,
  parameter int CREDIT_DEPTH    = 12,
  parameter int ERR_CNT_W       = 16
) (
  input  logic                       sclk,
  input  logic                       srst_n,
  input  logic                       clear_i,
  input  logic                       pipe2dll_valid_i,
  input  logic [PIPE_DATA_WIDTH-1:0] pipe2dll_data_i,
  output logic                       init1_received_o,
  output logic                       init2_received_o,
  output logic [CREDIT_DEPTH-1:0]    ep_cl_p_h_o,
  output logic [CREDIT_DEPTH-1:0]    ep_cl_p_d_o,
  output logic [CREDIT_DEPTH-1:0]    ep_cl_np_h_o,
  output logic [CREDIT_DEPTH-1:0]    ep_cl_np_d_o,
  output logic [CREDIT_DEPTH-1:0]    ep_cl_cpl_h_o,
  output logic [CREDIT_DEPTH-1:0]    ep_cl_cpl_d_o,
  output logic [CREDIT_DEPTH-1:0]    ep_cc_p_h_o,
  output logic [CREDIT_DEPTH-1:0]    ep_cc_p_d_o,
  output logic [CREDIT_DEPTH-1:0]    ep_cc_np_h_o,
  output logic [CREDIT_DEPTH-1:0]    ep_cc_np_d_o,
  output logic [CREDIT_DEPTH-1:0]    ep_cc_cpl_h_o,
  output logic [CREDIT_DEPTH-1:0]    ep_cc_cpl_d_o,
  output logic                       ack_valid_o,
  output logic [11:0]                ack_seq_o,
  output logic                       nak_valid_o,
  output logic [11:0]                nak_seq_o,
  output logic [ERR_CNT_W-1:0]       crc_err_cnt_o,
  output logic [ERR_CNT_W-1:0]       unk_type_cnt_o
);

  localparam int          NW        = $clog2(SLOT_CNT + 1);
  localparam logic [15:0] SDP_TOKEN = 16'hACF0;
  localparam logic [15:0] CRC_POLY  = 16'h100B;

  logic flush;
  assign flush = !srst_n || clear_i;

  // Lanes above the last slot are never decoded.
  logic unused_beat;
  assign unused_beat = ^pipe2dll_data_i;

  function automatic logic [15:0] crc_lfsr(input logic [31:0] body);
    logic [15:0] lfsr;
    lfsr = 16'hFFFF;
    for (int i = 31; i >= 0; i--) begin
      lfsr = {lfsr[14:0], 1'b0} ^ (CRC_POLY & {16{lfsr[15] ^ body[i]}});
    end
    return lfsr;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_add(input logic [ERR_CNT_W-1:0] a,
                                                   input logic [NW-1:0] n);
    logic [ERR_CNT_W:0] sum;
    sum = {1'b0, a} + (ERR_CNT_W + 1)'(n);
    return sum[ERR_CNT_W] ? '1 : sum[ERR_CNT_W-1:0];
  endfunction

  // Stage 1 keeps slot bits [63:16]; the framing token is reduced to an active bit.
  logic                s1_valid_q;
  logic [SLOT_CNT-1:0] s1_active_q;
  logic [47:0]         s1_slot_q [SLOT_CNT];

  always_ff @(posedge sclk) begin
    if (flush) begin
      s1_valid_q  <= 1'b0;
      s1_active_q <= '0;
      for (int k = 0; k < SLOT_CNT; k++) s1_slot_q[k] <= '0;
    end else begin
      s1_valid_q <= pipe2dll_valid_i;
      for (int k = 0; k < SLOT_CNT; k++) begin
        s1_active_q[k] <= pipe2dll_valid_i && (pipe2dll_data_i[64*k +: 16] == SDP_TOKEN);
        s1_slot_q[k]   <= pipe2dll_data_i[64*k+16 +: 48];
      end
    end
  end

  logic [SLOT_CNT-1:0]     crc_ok;
  logic [7:0]              slot_type [SLOT_CNT];
  logic [CREDIT_DEPTH-1:0] slot_hdr  [SLOT_CNT];
  logic [CREDIT_DEPTH-1:0] slot_dat  [SLOT_CNT];
  logic [11:0]             slot_seq  [SLOT_CNT];

  for (genvar k = 0; k < SLOT_CNT; k++) begin : g_slot
    assign crc_ok[k]    = (s1_slot_q[k][47:32] == ~crc_lfsr(s1_slot_q[k][31:0]));
    assign slot_type[k] = s1_slot_q[k][7:0];
    assign slot_hdr[k]  = CREDIT_DEPTH'({s1_slot_q[k][13:8], s1_slot_q[k][23:22]});
    assign slot_seq[k]  = {s1_slot_q[k][19:16], s1_slot_q[k][31:24]};
    assign slot_dat[k]  = CREDIT_DEPTH'(slot_seq[k]);
  end

  logic [CREDIT_DEPTH-1:0] cl_h_q [3];
  logic [CREDIT_DEPTH-1:0] cl_h_d [3];
  logic [CREDIT_DEPTH-1:0] cl_d_q [3];
  logic [CREDIT_DEPTH-1:0] cl_d_d [3];
  logic [CREDIT_DEPTH-1:0] cc_h_q [3];
  logic [CREDIT_DEPTH-1:0] cc_h_d [3];
  logic [CREDIT_DEPTH-1:0] cc_d_q [3];
  logic [CREDIT_DEPTH-1:0] cc_d_d [3];
  logic [2:0]              init1_q, init1_d;
  logic [2:0]              init2_q, init2_d;
  logic                    ack_valid_q, ack_valid_d;
  logic                    nak_valid_q, nak_valid_d;
  logic [11:0]             ack_seq_q, ack_seq_d;
  logic [11:0]             nak_seq_q, nak_seq_d;
  logic [ERR_CNT_W-1:0]    crc_cnt_q, crc_cnt_d;
  logic [ERR_CNT_W-1:0]    unk_cnt_q, unk_cnt_d;
  logic [NW-1:0]           n_crc, n_unk;
  logic                    init2_done;

  assign init2_done = &init2_q;

  // Slots are walked low to high so the highest index overwrites same-beat conflicts.
  always_comb begin
    cl_h_d      = cl_h_q;
    cl_d_d      = cl_d_q;
    cc_h_d      = cc_h_q;
    cc_d_d      = cc_d_q;
    init1_d     = init1_q;
    init2_d     = init2_q;
    ack_valid_d = 1'b0;
    nak_valid_d = 1'b0;
    ack_seq_d   = ack_seq_q;
    nak_seq_d   = nak_seq_q;
    n_crc       = '0;
    n_unk       = '0;
    for (int k = 0; k < SLOT_CNT; k++) begin
      if (s1_valid_q && s1_active_q[k]) begin
        if (!crc_ok[k]) begin
          n_crc = n_crc + NW'(1);
        end else begin
          case (slot_type[k])
            8'h40, 8'h50, 8'h60: begin
              for (int t = 0; t < 3; t++) begin
                if (!init2_done && slot_type[k][5:4] == 2'(t)) begin
                  cl_h_d[t]  = slot_hdr[k];
                  cl_d_d[t]  = slot_dat[k];
                  init1_d[t] = 1'b1;
                end
              end
            end
            8'hC0, 8'hD0, 8'hE0: begin
              for (int t = 0; t < 3; t++) begin
                if (!init2_done && slot_type[k][5:4] == 2'(t)) init2_d[t] = 1'b1;
              end
            end
            8'h80, 8'h90, 8'hA0: begin
              for (int t = 0; t < 3; t++) begin
                if (slot_type[k][5:4] == 2'(t)) begin
                  cc_h_d[t] = slot_hdr[k];
                  cc_d_d[t] = slot_dat[k];
                end
              end
            end
            8'h00: begin
              ack_valid_d = 1'b1;
              ack_seq_d   = slot_seq[k];
            end
            8'h10: begin
              nak_valid_d = 1'b1;
              nak_seq_d   = slot_seq[k];
            end
            default: n_unk = n_unk + NW'(1);
          endcase
        end
      end
    end
  end

  assign crc_cnt_d = sat_add(crc_cnt_q, n_crc);
  assign unk_cnt_d = sat_add(unk_cnt_q, n_unk);

  always_ff @(posedge sclk) begin
    if (flush) begin
      for (int t = 0; t < 3; t++) begin
        cl_h_q[t] <= '0;
        cl_d_q[t] <= '0;
        cc_h_q[t] <= '0;
        cc_d_q[t] <= '0;
      end
      init1_q     <= '0;
      init2_q     <= '0;
      ack_valid_q <= 1'b0;
      nak_valid_q <= 1'b0;
      ack_seq_q   <= '0;
      nak_seq_q   <= '0;
      crc_cnt_q   <= '0;
      unk_cnt_q   <= '0;
    end else begin
      for (int t = 0; t < 3; t++) begin
        cl_h_q[t] <= cl_h_d[t];
        cl_d_q[t] <= cl_d_d[t];
        cc_h_q[t] <= cc_h_d[t];
        cc_d_q[t] <= cc_d_d[t];
      end
      init1_q     <= init1_d;
      init2_q     <= init2_d;
      ack_valid_q <= ack_valid_d;
      nak_valid_q <= nak_valid_d;
      ack_seq_q   <= ack_seq_d;
      nak_seq_q   <= nak_seq_d;
      crc_cnt_q   <= crc_cnt_d;
      unk_cnt_q   <= unk_cnt_d;
    end
  end

  assign init1_received_o = &init1_q;
  assign init2_received_o = init2_done;
  assign ep_cl_p_h_o      = cl_h_q[0];
  assign ep_cl_p_d_o      = cl_d_q[0];
  assign ep_cl_np_h_o     = cl_h_q[1];
  assign ep_cl_np_d_o     = cl_d_q[1];
  assign ep_cl_cpl_h_o    = cl_h_q[2];
  assign ep_cl_cpl_d_o    = cl_d_q[2];
  assign ep_cc_p_h_o      = cc_h_q[0];
  assign ep_cc_p_d_o      = cc_d_q[0];
  assign ep_cc_np_h_o     = cc_h_q[1];
  assign ep_cc_np_d_o     = cc_d_q[1];
  assign ep_cc_cpl_h_o    = cc_h_q[2];
  assign ep_cc_cpl_d_o    = cc_d_q[2];
  assign ack_valid_o      = ack_valid_q;
  assign ack_seq_o        = ack_seq_q;
  assign nak_valid_o      = nak_valid_q;
  assign nak_seq_o        = nak_seq_q;
  assign crc_err_cnt_o    = crc_cnt_q;
  assign unk_type_cnt_o   = unk_cnt_q;

endmodule

// File: tb/tb_dll_dllp_rx_decoder.sv
// tb/tb_dll_dllp_rx_decoder.sv - Scoreboard bench for the DLLP receive decoder
// Stimulus pushes expected snapshots/pulses; a negedge monitor pops and compares.
module tb_dll_dllp_rx_decoder;

  localparam int           PW   = 256;
  localparam logic [63:0]  IDLE = 64'h0;
  localparam logic [127:0] FILL = {2{64'h1234_5678_9ABC_ACF0}};

  logic          sclk = 1'b0;
  logic          srst_n = 1'b0;
  logic          clear_i = 1'b0;
  logic          pipe2dll_valid_i = 1'b0;
  logic [PW-1:0] pipe2dll_data_i = '0;

  logic        init1_received_o, init2_received_o;
  logic [11:0] ep_cl_p_h_o, ep_cl_p_d_o, ep_cl_np_h_o, ep_cl_np_d_o, ep_cl_cpl_h_o, ep_cl_cpl_d_o;
  logic [11:0] ep_cc_p_h_o, ep_cc_p_d_o, ep_cc_np_h_o, ep_cc_np_d_o, ep_cc_cpl_h_o, ep_cc_cpl_d_o;
  logic        ack_valid_o, nak_valid_o;
  logic [11:0] ack_seq_o, nak_seq_o;
  logic [15:0] crc_err_cnt_o, unk_type_cnt_o;

  dll_dllp_rx_decoder #(
    .PIPE_DATA_WIDTH(PW), .SLOT_CNT(2), .CREDIT_DEPTH(12), .ERR_CNT_W(16)
  ) dut (
    .sclk(sclk), .srst_n(srst_n), .clear_i(clear_i),
    .pipe2dll_valid_i(pipe2dll_valid_i), .pipe2dll_data_i(pipe2dll_data_i),
    .init1_received_o(init1_received_o), .init2_received_o(init2_received_o),
    .ep_cl_p_h_o(ep_cl_p_h_o), .ep_cl_p_d_o(ep_cl_p_d_o),
    .ep_cl_np_h_o(ep_cl_np_h_o), .ep_cl_np_d_o(ep_cl_np_d_o),
    .ep_cl_cpl_h_o(ep_cl_cpl_h_o), .ep_cl_cpl_d_o(ep_cl_cpl_d_o),
    .ep_cc_p_h_o(ep_cc_p_h_o), .ep_cc_p_d_o(ep_cc_p_d_o),
    .ep_cc_np_h_o(ep_cc_np_h_o), .ep_cc_np_d_o(ep_cc_np_d_o),
    .ep_cc_cpl_h_o(ep_cc_cpl_h_o), .ep_cc_cpl_d_o(ep_cc_cpl_d_o),
    .ack_valid_o(ack_valid_o), .ack_seq_o(ack_seq_o),
    .nak_valid_o(nak_valid_o), .nak_seq_o(nak_seq_o),
    .crc_err_cnt_o(crc_err_cnt_o), .unk_type_cnt_o(unk_type_cnt_o)
  );

  always #5 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  typedef struct packed {
    int              due;
    logic            init1;
    logic            init2;
    logic [5:0][11:0] cl;
    logic [5:0][11:0] cc;
    logic            ack_v;
    logic [11:0]     ack_seq;
    logic            nak_v;
    logic [11:0]     nak_seq;
    logic [15:0]     crc_cnt;
    logic [15:0]     unk_cnt;
  } snap_t;

  typedef struct packed {
    int          due;
    logic [11:0] seq;
  } pulse_t;

  snap_t  snap_q[$];
  string  name_q[$];
  pulse_t ack_q[$];
  pulse_t nak_q[$];
  snap_t  exp_s;
  snap_t  mon_s;
  string  mon_n;
  pulse_t mon_p;
  int     n_checks = 0;
  int     n_fail = 0;

  logic [5:0][11:0] act_cl, act_cc;
  assign act_cl = {ep_cl_cpl_d_o, ep_cl_cpl_h_o, ep_cl_np_d_o, ep_cl_np_h_o, ep_cl_p_d_o, ep_cl_p_h_o};
  assign act_cc = {ep_cc_cpl_d_o, ep_cc_cpl_h_o, ep_cc_np_d_o, ep_cc_np_h_o, ep_cc_p_d_o, ep_cc_p_h_o};

  function automatic logic [15:0] lfsr16(input logic [31:0] b);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 31; i >= 0; i--) begin
      if (c[15] ^ b[i]) c = (c << 1) ^ 16'h100B;
      else              c = c << 1;
    end
    return c;
  endfunction

  function automatic logic [63:0] mk(input logic [7:0] typ, input logic [7:0] hdr, input logic [11:0] dat);
    logic [63:0] s;
    s          = 64'h0;
    s[15:0]    = 16'hACF0;
    s[23:16]   = typ;
    s[29:24]   = hdr[7:2];
    s[39:38]   = hdr[1:0];
    s[35:32]   = dat[11:8];
    s[47:40]   = dat[7:0];
    s[63:48]   = ~lfsr16(s[47:16]);
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %h want %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic send(input logic [63:0] s0, input logic [63:0] s1, output int due);
    @(posedge sclk);
    #1;
    pipe2dll_valid_i = 1'b1;
    pipe2dll_data_i  = {FILL, s1, s0};
    due = cyc + 2;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sclk);
      #1;
      pipe2dll_valid_i = 1'b0;
      pipe2dll_data_i  = '0;
    end
  endtask

  task automatic expect_snap(input string nm, input int due);
    exp_s.due = due;
    snap_q.push_back(exp_s);
    name_q.push_back(nm);
  endtask

  task automatic expect_ack(input int due, input logic [11:0] seq);
    ack_q.push_back('{due: due, seq: seq});
  endtask

  task automatic expect_nak(input int due, input logic [11:0] seq);
    nak_q.push_back('{due: due, seq: seq});
  endtask

  always @(negedge sclk) begin
    if (ack_valid_o === 1'b1) begin
      n_checks++;
      if (ack_q.size() == 0) begin
        n_fail++;
        $display("FAIL ack_pulse got unexpected pulse seq %h (cycle %0d)", ack_seq_o, cyc);
      end else begin
        mon_p = ack_q.pop_front();
        chk("ack_pulse_cycle", 32'(cyc), 32'(mon_p.due));
        chk("ack_pulse_seq", 32'(ack_seq_o), 32'(mon_p.seq));
      end
    end else if (ack_q.size() != 0 && ack_q[0].due <= cyc) begin
      mon_p = ack_q.pop_front();
      chk("ack_pulse_missing", 32'(ack_valid_o), 32'd1);
    end
    if (nak_valid_o === 1'b1) begin
      n_checks++;
      if (nak_q.size() == 0) begin
        n_fail++;
        $display("FAIL nak_pulse got unexpected pulse seq %h (cycle %0d)", nak_seq_o, cyc);
      end else begin
        mon_p = nak_q.pop_front();
        chk("nak_pulse_cycle", 32'(cyc), 32'(mon_p.due));
        chk("nak_pulse_seq", 32'(nak_seq_o), 32'(mon_p.seq));
      end
    end else if (nak_q.size() != 0 && nak_q[0].due <= cyc) begin
      mon_p = nak_q.pop_front();
      chk("nak_pulse_missing", 32'(nak_valid_o), 32'd1);
    end
    while (snap_q.size() != 0 && snap_q[0].due <= cyc) begin
      mon_s = snap_q.pop_front();
      mon_n = name_q.pop_front();
      chk({mon_n, ".cycle"}, 32'(cyc), 32'(mon_s.due));
      chk({mon_n, ".init1"}, 32'(init1_received_o), 32'(mon_s.init1));
      chk({mon_n, ".init2"}, 32'(init2_received_o), 32'(mon_s.init2));
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("%s.cl%0d", mon_n, i), 32'(act_cl[i]), 32'(mon_s.cl[i]));
        chk($sformatf("%s.cc%0d", mon_n, i), 32'(act_cc[i]), 32'(mon_s.cc[i]));
      end
      chk({mon_n, ".ack_valid"}, 32'(ack_valid_o), 32'(mon_s.ack_v));
      chk({mon_n, ".ack_seq"}, 32'(ack_seq_o), 32'(mon_s.ack_seq));
      chk({mon_n, ".nak_valid"}, 32'(nak_valid_o), 32'(mon_s.nak_v));
      chk({mon_n, ".nak_seq"}, 32'(nak_seq_o), 32'(mon_s.nak_seq));
      chk({mon_n, ".crc_cnt"}, 32'(crc_err_cnt_o), 32'(mon_s.crc_cnt));
      chk({mon_n, ".unk_cnt"}, 32'(unk_type_cnt_o), 32'(mon_s.unk_cnt));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] s_unk;
    int d;
    int d0;
    exp_s = '0;
    expect_snap("reset", 2);
    repeat (3) @(posedge sclk);
    #1 srst_n = 1'b1;

    send(mk(8'h40, 8'h20, 12'h100), IDLE, d);
    exp_s.cl[0] = 12'h020; exp_s.cl[1] = 12'h100;
    expect_snap("initfc1_p", d);
    send(mk(8'h50, 8'h08, 12'h040), IDLE, d);
    exp_s.cl[2] = 12'h008; exp_s.cl[3] = 12'h040;
    expect_snap("initfc1_np", d);
    send(IDLE, mk(8'h60, 8'h00, 12'h000), d);
    exp_s.init1 = 1'b1;
    expect_snap("initfc1_cpl_inf", d);

    send(mk(8'hC0, 8'h33, 12'h055), IDLE, d);
    expect_snap("initfc2_p", d);
    send(mk(8'hD0, 8'h33, 12'h055), IDLE, d);
    expect_snap("initfc2_np", d);
    send(mk(8'hE0, 8'h33, 12'h055), IDLE, d);
    exp_s.init2 = 1'b1;
    expect_snap("initfc2_cpl", d);
    idle(2);

    send(mk(8'h80, 8'h05, 12'h011), mk(8'h80, 8'h09, 12'h022), d);
    exp_s.cc[0] = 12'h009; exp_s.cc[1] = 12'h022;
    expect_snap("updfc_dual_p", d);
    send(mk(8'h90, 8'h0A, 12'h0B0), mk(8'hA0, 8'h0C, 12'h0D0), d);
    exp_s.cc[2] = 12'h00A; exp_s.cc[3] = 12'h0B0; exp_s.cc[4] = 12'h00C; exp_s.cc[5] = 12'h0D0;
    expect_snap("updfc_np_cpl", d);

    send(mk(8'h00, 8'h00, 12'h0F0), IDLE, d);
    exp_s.ack_v = 1'b1; exp_s.ack_seq = 12'h0F0;
    expect_snap("ack_good", d);
    expect_ack(d, 12'h0F0);
    send(mk(8'h00, 8'h00, 12'h3A5) ^ 64'h0000_0000_0001_0000, IDLE, d);
    exp_s.ack_v = 1'b0; exp_s.crc_cnt = 16'd1;
    expect_snap("ack_bad_crc", d);
    send(mk(8'h90, 8'h01, 12'h001) ^ 64'h8000_0000_0000_0000,
         mk(8'h80, 8'h02, 12'h002) ^ 64'h0000_0100_0000_0000, d);
    exp_s.crc_cnt = 16'd3;
    expect_snap("two_bad_crc", d);

    send(mk(8'h00, 8'h00, 12'h010), mk(8'h10, 8'h00, 12'h00F), d);
    exp_s.ack_v = 1'b1; exp_s.ack_seq = 12'h010; exp_s.nak_v = 1'b1; exp_s.nak_seq = 12'h00F;
    expect_snap("ack_nak_same_beat", d);
    expect_ack(d, 12'h010);
    expect_nak(d, 12'h00F);
    send(mk(8'h00, 8'h00, 12'h111), mk(8'h00, 8'h00, 12'h222), d);
    exp_s.nak_v = 1'b0; exp_s.ack_seq = 12'h222;
    expect_snap("two_acks_hi_wins", d);
    expect_ack(d, 12'h222);
    send(mk(8'h00, 8'h00, 12'h001), IDLE, d);
    exp_s.ack_seq = 12'h001;
    expect_snap("ack_back_to_back", d);
    expect_ack(d, 12'h001);
    send(IDLE, IDLE, d);
    exp_s.ack_v = 1'b0;
    expect_snap("valid_no_token", d);

    s_unk = mk(8'h30, 8'h00, 12'h000);
    for (int i = 0; i < 32767; i++) send(s_unk, s_unk, d);
    exp_s.unk_cnt = 16'hFFFE;
    expect_snap("unk_preload", d);
    send(s_unk, s_unk, d);
    exp_s.unk_cnt = 16'hFFFF;
    expect_snap("unk_sat_plus2", d);
    send(IDLE, s_unk, d);
    expect_snap("unk_sat_hold", d);

    send(mk(8'h40, 8'h7F, 12'h7FF), mk(8'hC0, 8'h7F, 12'h7FF), d);
    expect_snap("late_init_dropped", d);
    idle(3);

    send(mk(8'h80, 8'h44, 12'h444), IDLE, d0);
    @(posedge sclk);
    #1;
    clear_i          = 1'b1;
    pipe2dll_valid_i = 1'b1;
    pipe2dll_data_i  = {FILL, IDLE, mk(8'hA0, 8'h55, 12'h555)};
    exp_s = '0;
    for (int i = 0; i < 4; i++) expect_snap($sformatf("clear_%0d", i), d0 + i);
    @(posedge sclk);
    #1;
    clear_i          = 1'b0;
    pipe2dll_valid_i = 1'b0;
    pipe2dll_data_i  = '0;
    idle(6);

    chk("snap_queue_drained", 32'(snap_q.size()), 32'd0);
    chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);
    chk("nak_queue_drained", 32'(nak_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
